// File: rtl/memory_access.sv
// Pipeline MEM stage: issues load/store requests on the data bus, aligns and extends load data,
// builds store lanes/strobes, and produces the MEM/WB bundle plus MEM-stage forwarding outputs.
module memory_access #(
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ex_valid,
    input  logic [31:0]          ex_inst,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      ex_alu_result,
    input  logic [XLEN-1:0]      ex_store_data,
    input  logic [4:0]           ex_reg_dest_addr,
    input  logic                 ex_reg_write_enable,
    input  logic                 advance,

    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [XLEN/8-1:0]    dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_addr_ok,
    input  logic                 dresp_data_ok,
    input  logic [XLEN-1:0]      dresp_data,

    output logic                 wb_valid,
    output logic [31:0]          wb_inst,
    output logic [XLEN-1:0]      wb_pc,
    output logic [4:0]           wb_reg_dest_addr,
    output logic                 wb_reg_write_enable,
    output logic [XLEN-1:0]      wb_result,
    output logic                 wb_misaligned,

    output logic [4:0]           forward_reg_dest_addr,
    output logic                 forward_reg_write_enable,
    output logic [XLEN-1:0]      forward_reg_write_data,
    output logic                 forward_data_ready,
    output logic                 ok
);

    localparam int NBYTES = XLEN / 8;
    localparam int OFFW   = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [XLEN-1:0]    r_data;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_mem;
    logic [1:0]         w_size;
    logic [OFFW-1:0]    w_off;
    logic [3:0]         w_bytes;
    logic [OFFW-1:0]    w_align_mask;
    logic               w_misaligned_addr;
    logic               w_misaligned;
    logic               w_req;
    logic               w_done;
    logic [OFFW+1:0]    w_lane_end;
    logic [NBYTES-1:0]  w_lane_hit;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_load_ext;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_opcode   = ex_inst[6:0];
    assign w_funct3   = ex_inst[14:12];
    assign w_is_load  = (w_opcode == 7'b0000011) && (w_funct3 != 3'b111);
    assign w_is_store = (w_opcode == 7'b0100011) && !w_funct3[2];
    assign w_is_mem   = ex_valid && (w_is_load || w_is_store);

    assign w_size       = w_funct3[1:0];
    assign w_off        = ex_alu_result[OFFW-1:0];
    assign w_bytes      = 4'd1 << w_size;
    assign w_align_mask = OFFW'(w_bytes - 4'd1);

    assign w_misaligned_addr = |(w_off & w_align_mask);
    assign w_misaligned      = w_is_mem && w_misaligned_addr;
    assign w_req             = w_is_mem && !w_misaligned_addr;
    assign w_done            = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Store byte lanes: lane gi is written when off <= gi < off + bytes
    // ------------------------------------------------------------------
    assign w_lane_end = (OFFW+2)'(w_off) + (OFFW+2)'(w_bytes);

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign w_lane_hit[gi]  = (OFFW'(gi) >= w_off) && ((OFFW+2)'(gi) < w_lane_end);
            assign dreq_strobe[gi] = w_is_store && w_lane_hit[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request channel: fields follow the EX inputs, which stay frozen while ok=0
    // ------------------------------------------------------------------
    assign dreq_valid = !reset && w_req && (r_state != S_DONE);
    assign dreq_addr  = ex_alu_result;
    assign dreq_size  = {1'b0, w_size};
    assign dreq_data  = ex_store_data << {w_off, 3'b000};

    // ------------------------------------------------------------------
    // Request FSM and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (dresp_data_ok) begin
                            r_data  <= dresp_data;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (dresp_data_ok) begin
                        r_data  <= dresp_data;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (advance) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    assign w_shifted = r_data >> {w_off, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (w_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_ext = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            3'b110:  w_load_ext = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB bundle, forwarding and completion
    // ------------------------------------------------------------------
    assign wb_valid            = ex_valid;
    assign wb_inst             = ex_inst;
    assign wb_pc               = ex_pc;
    assign wb_reg_dest_addr    = ex_reg_dest_addr;
    assign wb_reg_write_enable = ex_reg_write_enable && !w_misaligned;
    assign wb_result           = w_is_load ? w_load_ext : ex_alu_result;
    assign wb_misaligned       = w_misaligned;

    assign ok = !w_is_mem || w_misaligned || w_done;

    assign forward_reg_dest_addr    = ex_reg_dest_addr;
    assign forward_reg_write_enable = ex_valid && wb_reg_write_enable;
    assign forward_reg_write_data   = wb_result;
    assign forward_data_ready       = ok;

    // addr_ok carries no meaning for this stage; the bus completes on data_ok
    assign w_unused = &{1'b0, dresp_addr_ok};

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access: hand-computed vectors covering ALU passthrough,
// loads with delayed/immediate responses, stores, misalignment and reset mid-transaction.
module tb_memory_access;

    localparam int XLEN = 64;

    logic              clk;
    logic              reset;
    logic              ex_valid;
    logic [31:0]       ex_inst;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_alu_result;
    logic [XLEN-1:0]   ex_store_data;
    logic [4:0]        ex_reg_dest_addr;
    logic              ex_reg_write_enable;
    logic              advance;
    logic              dreq_valid;
    logic [XLEN-1:0]   dreq_addr;
    logic [2:0]        dreq_size;
    logic [XLEN/8-1:0] dreq_strobe;
    logic [XLEN-1:0]   dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [XLEN-1:0]   dresp_data;
    logic              wb_valid;
    logic [31:0]       wb_inst;
    logic [XLEN-1:0]   wb_pc;
    logic [4:0]        wb_reg_dest_addr;
    logic              wb_reg_write_enable;
    logic [XLEN-1:0]   wb_result;
    logic              wb_misaligned;
    logic [4:0]        forward_reg_dest_addr;
    logic              forward_reg_write_enable;
    logic [XLEN-1:0]   forward_reg_write_data;
    logic              forward_data_ready;
    logic              ok;

    int n_tests = 0;
    int n_fail  = 0;

    memory_access #(.XLEN(XLEN)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .ex_valid                 (ex_valid),
        .ex_inst                  (ex_inst),
        .ex_pc                    (ex_pc),
        .ex_alu_result            (ex_alu_result),
        .ex_store_data            (ex_store_data),
        .ex_reg_dest_addr         (ex_reg_dest_addr),
        .ex_reg_write_enable      (ex_reg_write_enable),
        .advance                  (advance),
        .dreq_valid               (dreq_valid),
        .dreq_addr                (dreq_addr),
        .dreq_size                (dreq_size),
        .dreq_strobe              (dreq_strobe),
        .dreq_data                (dreq_data),
        .dresp_addr_ok            (dresp_addr_ok),
        .dresp_data_ok            (dresp_data_ok),
        .dresp_data               (dresp_data),
        .wb_valid                 (wb_valid),
        .wb_inst                  (wb_inst),
        .wb_pc                    (wb_pc),
        .wb_reg_dest_addr         (wb_reg_dest_addr),
        .wb_reg_write_enable      (wb_reg_write_enable),
        .wb_result                (wb_result),
        .wb_misaligned            (wb_misaligned),
        .forward_reg_dest_addr    (forward_reg_dest_addr),
        .forward_reg_write_enable (forward_reg_write_enable),
        .forward_reg_write_data   (forward_reg_write_data),
        .forward_data_ready       (forward_data_ready),
        .ok                       (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] inst, input logic [63:0] addr,
                          input logic [63:0] sdata, input logic [4:0] rd, input logic we);
        ex_valid            = v;
        ex_inst             = inst;
        ex_pc               = 64'h8000_0000 + addr;
        ex_alu_result       = addr;
        ex_store_data       = sdata;
        ex_reg_dest_addr    = rd;
        ex_reg_write_enable = we;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        advance = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = '0;
        set_ex(1'b1, 32'h0000_3003, 64'h5000, 64'h0, 5'd1, 1'b1);   // LD presented during reset
        step();
        step();
        #1;
        check("reset_dreq_valid", {63'd0, dreq_valid}, 64'd0);

        // Leave reset with nothing in flight
        reset = 1'b0;
        set_ex(1'b0, 32'h0, 64'h0, 64'h0, 5'd0, 1'b0);
        #1;
        check("idle_ok", {63'd0, ok}, 64'd1);
        check("idle_dreq_valid", {63'd0, dreq_valid}, 64'd0);

        // ALU op: ADDI x5
        step();
        set_ex(1'b1, 32'h0050_0293, 64'h1234, 64'h0, 5'd5, 1'b1);
        #1;
        check("alu_ok", {63'd0, ok}, 64'd1);
        check("alu_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("alu_wb_result", wb_result, 64'h1234);
        check("alu_fwd_we", {63'd0, forward_reg_write_enable}, 64'd1);
        check("alu_fwd_data", forward_reg_write_data, 64'h1234);
        check("alu_fwd_addr", {59'd0, forward_reg_dest_addr}, 64'd5);

        // LB at 0x1003, data_ok two cycles after the request cycle
        step();
        set_ex(1'b1, 32'h0000_0303, 64'h1003, 64'h0, 5'd6, 1'b1);
        dresp_data = 64'h0000_0000_8000_0000;
        #1;
        check("lb_c0_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("lb_c0_addr", dreq_addr, 64'h1003);
        check("lb_c0_size", {61'd0, dreq_size}, 64'd0);
        check("lb_c0_strobe", {56'd0, dreq_strobe}, 64'd0);
        check("lb_c0_ok", {63'd0, ok}, 64'd0);
        step();
        advance = 1'b1;                                   // must be ignored while ok=0
        #1;
        check("lb_c1_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("lb_c1_ok", {63'd0, ok}, 64'd0);
        step();
        advance = 1'b0;
        dresp_data_ok = 1'b1;
        #1;
        check("lb_c2_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("lb_c2_addr", dreq_addr, 64'h1003);
        check("lb_c2_size", {61'd0, dreq_size}, 64'd0);
        step();
        dresp_data_ok = 1'b0;
        dresp_data = 64'h0;
        #1;
        check("lb_done_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("lb_done_ok", {63'd0, ok}, 64'd1);
        check("lb_done_wb_result", wb_result, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_done_fwd_ready", {63'd0, forward_data_ready}, 64'd1);
        step();
        #1;
        check("lb_hold_ok", {63'd0, ok}, 64'd1);
        check("lb_hold_wb_result", wb_result, 64'hFFFF_FFFF_FFFF_FF80);
        advance = 1'b1;

        // LHU at 0x2006, data_ok in the request cycle
        step();
        advance = 1'b0;
        set_ex(1'b1, 32'h0000_5383, 64'h2006, 64'h0, 5'd7, 1'b1);
        dresp_data = 64'hABCD_0000_0000_0000;
        dresp_data_ok = 1'b1;
        #1;
        check("lhu_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("lhu_size", {61'd0, dreq_size}, 64'd1);
        check("lhu_ok_req", {63'd0, ok}, 64'd0);
        step();
        dresp_data_ok = 1'b0;
        dresp_data = 64'h0;
        #1;
        check("lhu_done_ok", {63'd0, ok}, 64'd1);
        check("lhu_done_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("lhu_wb_result", wb_result, 64'hABCD);
        advance = 1'b1;

        // SH at 0x3002
        step();
        advance = 1'b0;
        set_ex(1'b1, 32'h0000_1023, 64'h3002, 64'h1122_3344, 5'd0, 1'b0);
        #1;
        check("sh_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("sh_size", {61'd0, dreq_size}, 64'd1);
        check("sh_strobe", {56'd0, dreq_strobe}, 64'h0C);
        check("sh_data", dreq_data, 64'h0000_1122_3344_0000);
        check("sh_ok_req", {63'd0, ok}, 64'd0);
        step();
        dresp_data_ok = 1'b1;
        #1;
        check("sh_busy_ok", {63'd0, ok}, 64'd0);
        step();
        dresp_data_ok = 1'b0;
        #1;
        check("sh_done_ok", {63'd0, ok}, 64'd1);
        check("sh_wb_we", {63'd0, wb_reg_write_enable}, 64'd0);
        advance = 1'b1;

        // LW at 0x4002: misaligned
        step();
        advance = 1'b0;
        set_ex(1'b1, 32'h0000_2403, 64'h4002, 64'h0, 5'd8, 1'b1);
        #1;
        check("lw_mis_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        check("lw_mis_flag", {63'd0, wb_misaligned}, 64'd1);
        check("lw_mis_ok", {63'd0, ok}, 64'd1);
        check("lw_mis_wb_we", {63'd0, wb_reg_write_enable}, 64'd0);
        check("lw_mis_fwd_we", {63'd0, forward_reg_write_enable}, 64'd0);
        advance = 1'b1;

        // LD at 0x5000, reset while BUSY, then a late data_ok
        step();
        advance = 1'b0;
        set_ex(1'b1, 32'h0000_3483, 64'h5000, 64'h0, 5'd9, 1'b1);
        #1;
        check("ld_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        step();
        reset = 1'b1;
        #1;
        check("rst_busy_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        step();
        reset = 1'b0;
        set_ex(1'b0, 32'h0, 64'h0, 64'h0, 5'd0, 1'b0);
        dresp_data_ok = 1'b1;                             // late response, nothing pending
        dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("late_ok", {63'd0, ok}, 64'd1);
        check("late_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        step();
        dresp_data_ok = 1'b0;
        set_ex(1'b1, 32'h0000_3483, 64'h5000, 64'h0, 5'd9, 1'b1);
        #1;
        check("ld2_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        check("ld2_ok", {63'd0, ok}, 64'd0);
        dresp_data_ok = 1'b1;
        dresp_data = 64'h0123_4567_89AB_CDEF;
        step();
        dresp_data_ok = 1'b0;
        #1;
        check("ld2_done_ok", {63'd0, ok}, 64'd1);
        check("ld2_wb_result", wb_result, 64'h0123_4567_89AB_CDEF);
        advance = 1'b1;

        // LW (signed) at 0x6004, immediate response
        step();
        advance = 1'b0;
        set_ex(1'b1, 32'h0000_2503, 64'h6004, 64'h0, 5'd10, 1'b1);
        dresp_data = 64'h8765_4321_0000_0000;
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        #1;
        check("lw_wb_result", wb_result, 64'hFFFF_FFFF_8765_4321);
        advance = 1'b1;

        // LWU at 0x6004, immediate response
        step();
        advance = 1'b0;
        set_ex(1'b1, 32'h0000_6503, 64'h6004, 64'h0, 5'd10, 1'b1);
        dresp_data = 64'h8765_4321_0000_0000;
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        #1;
        check("lwu_wb_result", wb_result, 64'h0000_0000_8765_4321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
